// File: rtl/timer_regs_pkg.sv
// rtl/timer_regs_pkg.sv - interval timer register map, control bits and sequencer states
package timer_regs_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] CTRL_RUN  = 16'(1 << CTRL_ITO) | 16'(1 << CTRL_CONT) | 16'(1 << CTRL_START);
  localparam logic [15:0] CTRL_HALT = 16'(1 << CTRL_STOP);

  typedef enum logic [3:0] {
    ST_INIT_PL,
    ST_INIT_PH,
    ST_CLR,
    ST_START,
    ST_IDLE,
    ST_ACK,
    ST_HOLD,
    ST_STOP,
    ST_PAUSED
  } seq_state_t;

endpackage

// File: rtl/lab3_timer_sequencer_if.sv
// rtl/lab3_timer_sequencer_if.sv - write-only bus and irq between sequencer and interval timer
interface lab3_timer_sequencer_if;

  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_irq
  );

endinterface

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - packed BCD up-counter, wraps at all-nines, clear beats increment
module bcd_counter #(
  parameter int BCD_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    inc,
  input  logic                    clr,
  output logic [4*BCD_DIGITS-1:0] count
);

  logic [4*BCD_DIGITS-1:0] count_inc;
  logic                    carry;

  // Ripple the carry from digit 0 upward; a digit at 9 rolls to 0 and passes the carry on.
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/lab3_timer_sequencer.sv
// rtl/lab3_timer_sequencer.sv - programs the interval timer, acknowledges timeouts, counts them in BCD
module lab3_timer_sequencer
  import timer_regs_pkg::*;
#(
  parameter logic [31:0] PERIOD     = 32'h017D783F,
  parameter int          BCD_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [31:0]                   period_in,
  input  logic                          period_load,
  input  logic                          count_clr,
  lab3_timer_sequencer_if.master        bus,
  output logic                          tick,
  output logic [4*BCD_DIGITS-1:0]       bcd_count,
  output logic                          busy
);

  seq_state_t  state;
  seq_state_t  state_next;
  logic [31:0] period_reg;
  logic        pend_load;
  logic        resume;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT_PL: state_next = ST_INIT_PH;
      ST_INIT_PH: state_next = resume ? ST_CLR : ST_PAUSED;
      ST_CLR:     state_next = ST_START;
      ST_START:   state_next = ST_IDLE;
      ST_IDLE: begin
        if (bus.tmr_irq)  state_next = ST_ACK;
        else if (pend_load) state_next = ST_INIT_PL;
        else if (!enable) state_next = ST_STOP;
      end
      ST_ACK:     state_next = ST_HOLD;
      ST_HOLD:    state_next = ST_IDLE;
      ST_STOP:    state_next = ST_PAUSED;
      ST_PAUSED: begin
        if (pend_load)    state_next = ST_INIT_PL;
        else if (enable)  state_next = ST_CLR;
      end
      default:    state_next = ST_INIT_PL;
    endcase
  end

  // The bus registers present the write belonging to the state just left.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ADDR_STATUS;
    wr_data = '0;
    case (state)
      ST_INIT_PL: begin wr_en = 1'b1; wr_addr = ADDR_PERIODL; wr_data = period_reg[15:0];  end
      ST_INIT_PH: begin wr_en = 1'b1; wr_addr = ADDR_PERIODH; wr_data = period_reg[31:16]; end
      ST_CLR:     begin wr_en = 1'b1; wr_addr = ADDR_STATUS;  wr_data = '0;                end
      ST_START:   begin wr_en = 1'b1; wr_addr = ADDR_CONTROL; wr_data = CTRL_RUN;          end
      ST_ACK:     begin wr_en = 1'b1; wr_addr = ADDR_STATUS;  wr_data = '0;                end
      ST_STOP:    begin wr_en = 1'b1; wr_addr = ADDR_CONTROL; wr_data = CTRL_HALT;         end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= ST_INIT_PL;
      period_reg         <= PERIOD;
      pend_load          <= 1'b0;
      resume             <= 1'b1;
      bus.tmr_chipselect <= 1'b0;
      bus.tmr_write_n    <= 1'b1;
      bus.tmr_address    <= ADDR_STATUS;
      bus.tmr_writedata  <= '0;
      tick               <= 1'b0;
      busy               <= 1'b1;
    end else begin
      state <= state_next;
      // A load landing during INIT_PL keeps pend_load set so the new value is written again.
      if (period_load) begin
        period_reg <= period_in;
        pend_load  <= 1'b1;
      end else if (state == ST_INIT_PL) begin
        pend_load <= 1'b0;
      end
      if (state == ST_PAUSED)    resume <= 1'b0;
      else if (state == ST_IDLE) resume <= 1'b1;
      bus.tmr_chipselect <= wr_en;
      bus.tmr_write_n    <= ~wr_en;
      bus.tmr_address    <= wr_addr;
      bus.tmr_writedata  <= wr_data;
      tick               <= (state == ST_ACK);
      busy               <= !((state == ST_IDLE) || (state == ST_PAUSED));
    end
  end

  bcd_counter #(
    .BCD_DIGITS(BCD_DIGITS)
  ) u_bcd (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (state == ST_ACK),
    .clr    (count_clr),
    .count  (bcd_count)
  );

endmodule

// File: tb/tb_lab3_timer_sequencer.sv
// tb/tb_lab3_timer_sequencer.sv - randomized bench with a write-plan reference model of the timer sequencer
module tb_lab3_timer_sequencer;

  localparam logic [31:0] PERIOD = 32'h017D783F;
  localparam int          MOD    = 10000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] period_in;
  logic        period_load;
  logic        count_clr;
  logic        irq;
  logic        tick;
  logic [15:0] bcd_count;
  logic        busy;

  lab3_timer_sequencer_if bus_if ();
  assign bus_if.tmr_irq = irq;

  lab3_timer_sequencer #(
    .PERIOD    (PERIOD),
    .BCD_DIGITS(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .period_in  (period_in),
    .period_load(period_load),
    .count_clr  (count_clr),
    .bus        (bus_if),
    .tick       (tick),
    .bcd_count  (bcd_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef enum int {K_PL, K_PH, K_CLR, K_START, K_ACK, K_HOLD, K_STOP} step_e;

  // Reference model: a queue of bus steps still to be issued; empty means waiting (idle or paused).
  step_e       plan[$];
  bit          m_paused;
  logic [31:0] m_period;
  bit          m_pend;
  int          m_count;
  logic        e_wr;
  logic [2:0]  e_addr;
  logic [15:0] e_data;
  logic        e_tick;
  logic        e_busy;

  int checks = 0;
  int errors = 0;
  int irq_rate = 0;
  bit clr_pend = 0;

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    logic [15:0] r;
    v = n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    step_e s;
    bit    inc;
    inc = 0;
    if (!reset_n) begin
      plan.delete();
      plan.push_back(K_PL); plan.push_back(K_PH); plan.push_back(K_CLR); plan.push_back(K_START);
      m_paused = 0; m_period = PERIOD; m_pend = 0; m_count = 0;
      e_wr = 0; e_addr = 0; e_data = 0; e_tick = 0; e_busy = 1;
      return;
    end
    e_wr = 0; e_addr = 0; e_data = 0; e_tick = 0; e_busy = 1;
    if (plan.size() > 0) begin
      s = plan.pop_front();
      case (s)
        K_PL:    begin e_wr = 1; e_addr = 3'd2; e_data = m_period[15:0]; m_pend = 0; end
        K_PH:    begin e_wr = 1; e_addr = 3'd3; e_data = m_period[31:16]; end
        K_CLR:   begin e_wr = 1; e_addr = 3'd0; e_data = 16'h0000; end
        K_START: begin e_wr = 1; e_addr = 3'd1; e_data = 16'h0007; end
        K_ACK:   begin e_wr = 1; e_addr = 3'd0; e_data = 16'h0000; e_tick = 1; inc = 1; end
        K_STOP:  begin e_wr = 1; e_addr = 3'd1; e_data = 16'h0008; end
        default: ;
      endcase
    end else begin
      e_busy = 0;
      if (!m_paused) begin
        if (irq) begin
          plan.push_back(K_ACK); plan.push_back(K_HOLD);
        end else if (m_pend) begin
          plan.push_back(K_PL); plan.push_back(K_PH); plan.push_back(K_CLR); plan.push_back(K_START);
        end else if (!enable) begin
          plan.push_back(K_STOP);
          m_paused = 1;
        end
      end else begin
        if (m_pend) begin
          plan.push_back(K_PL); plan.push_back(K_PH);
        end else if (enable) begin
          plan.push_back(K_CLR); plan.push_back(K_START);
          m_paused = 0;
        end
      end
    end
    if (period_load) begin
      m_period = period_in;
      m_pend   = 1;
    end
    if (count_clr) m_count = 0;
    else if (inc)  m_count = (m_count + 1) % MOD;
  endtask

  // One clock: model advances at the edge, DUT compared at the falling edge, then the timer slave reacts.
  task automatic cyc();
    bit do_clear;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cycle_model",
        64'({bus_if.tmr_chipselect, bus_if.tmr_write_n, bus_if.tmr_address, bus_if.tmr_writedata, tick, busy, bcd_count}),
        64'({e_wr, ~e_wr, e_addr, e_data, e_tick, e_busy, to_bcd(m_count)}));
    do_clear = clr_pend;
    clr_pend = bus_if.tmr_chipselect && !bus_if.tmr_write_n && (bus_if.tmr_address == 3'd0);
    if (do_clear) irq = 1'b0;
    else if (!irq && !clr_pend && ($urandom_range(99) < irq_rate)) irq = 1'b1;
  endtask

  task automatic expect_next_write(input string name, input logic [2:0] a, input logic [15:0] d);
    cyc();
    chk(name, 64'({bus_if.tmr_chipselect, bus_if.tmr_write_n, bus_if.tmr_address, bus_if.tmr_writedata}),
        64'({1'b1, 1'b0, a, d}));
  endtask

  task automatic expect_write(input string name, input int budget, input logic [2:0] a, input logic [15:0] d);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc();
      if (bus_if.tmr_chipselect && !bus_if.tmr_write_n) got = 1;
    end
    if (got) chk(name, 64'({bus_if.tmr_address, bus_if.tmr_writedata}), 64'({a, d}));
    else     chk({name, "_timeout"}, 64'(got), 64'(1));
  endtask

  task automatic count_ticks(input int n, output int t);
    t = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (tick) t++;
    end
  endtask

  initial begin
    int          lat;
    int          ticks;
    bit          saw_carry;
    bit          saw_wrap;
    logic [15:0] prev;

    reset_n = 1'b0; enable = 1'b1; period_in = '0; period_load = 1'b0; count_clr = 1'b0; irq = 1'b0;
    repeat (3) cyc();
    chk("reset_outputs", 64'({bus_if.tmr_chipselect, bus_if.tmr_write_n, bus_if.tmr_address,
                              bus_if.tmr_writedata, tick, busy, bcd_count}),
        64'({1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000}));
    reset_n = 1'b1;

    expect_next_write("init_periodl", 3'd2, 16'h783F);
    expect_next_write("init_periodh", 3'd3, 16'h017D);
    expect_next_write("init_clr",     3'd0, 16'h0000);
    expect_next_write("init_start",   3'd1, 16'h0007);
    cyc();
    chk("init_idle_busy", 64'(busy), 64'(0));

    irq = 1'b1;
    lat = 0;
    for (int i = 0; i < 10 && !tick; i++) begin cyc(); lat++; end
    chk("ack_latency", 64'(lat), 64'(2));
    chk("ack_write", 64'({bus_if.tmr_chipselect, bus_if.tmr_address, bus_if.tmr_writedata}), 64'({1'b1, 3'd0, 16'h0}));
    chk("ack_bcd", 64'(bcd_count), 64'(16'h0001));
    count_ticks(6, ticks);
    chk("irq_held_no_retick", 64'(ticks), 64'(0));

    count_clr = 1'b1; cyc(); count_clr = 1'b0; cyc();
    chk("count_clr_idle", 64'(bcd_count), 64'(16'h0000));

    irq_rate = 100; ticks = 0; prev = bcd_count; saw_carry = 0; saw_wrap = 0;
    for (int i = 0; i < 60000 && ticks < 10000; i++) begin
      cyc();
      if (tick) begin
        ticks++;
        if (prev == 16'h0009 && bcd_count == 16'h0010) saw_carry = 1;
        if (prev == 16'h9999 && bcd_count == 16'h0000) saw_wrap = 1;
        if (ticks == 10000) irq_rate = 0;
      end
      prev = bcd_count;
    end
    irq_rate = 0;
    chk("rounds_done", 64'(ticks), 64'(10000));
    chk("bcd_carry_0009_0010", 64'(saw_carry), 64'(1));
    chk("bcd_wrap_9999_0000", 64'(saw_wrap), 64'(1));
    chk("rounds_final_bcd", 64'(bcd_count), 64'(16'h0000));

    repeat (4) cyc();
    irq = 1'b1;
    repeat (6) cyc();
    chk("bcd_before_clr_ack", 64'(bcd_count), 64'(16'h0001));
    irq = 1'b1; cyc(); count_clr = 1'b1; cyc(); count_clr = 1'b0;
    chk("clr_with_ack", 64'({tick, bcd_count}), 64'({1'b1, 16'h0000}));

    repeat (4) cyc();
    irq = 1'b1; cyc();
    period_load = 1'b1; period_in = 32'h0000_0031; cyc();
    period_load = 1'b0;
    chk("load_during_ack_tick", 64'(tick), 64'(1));
    expect_write("reload_periodl", 6, 3'd2, 16'h0031);
    expect_next_write("reload_periodh", 3'd3, 16'h0000);
    expect_next_write("reload_clr",     3'd0, 16'h0000);
    expect_next_write("reload_start",   3'd1, 16'h0007);

    repeat (3) cyc();
    enable = 1'b0;
    expect_write("pause_stop", 5, 3'd1, 16'h0008);
    count_ticks(10, ticks);
    chk("paused_no_tick", 64'(ticks), 64'(0));
    chk("paused_not_busy", 64'(busy), 64'(0));
    enable = 1'b1;
    expect_write("resume_clr", 5, 3'd0, 16'h0000);
    expect_next_write("resume_start", 3'd1, 16'h0007);
    count_ticks(8, ticks);
    chk("resume_no_tick", 64'(ticks), 64'(0));

    irq_rate = 25;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(99) < 4) enable = ~enable;
      period_load = ($urandom_range(99) < 3);
      period_in   = $urandom;
      count_clr   = ($urandom_range(99) < 2);
    end

    irq_rate = 0; enable = 1'b1; period_load = 1'b0; count_clr = 1'b0;
    repeat (30) cyc();
    period_load = 1'b1; period_in = 32'h0000_1234; cyc();
    period_load = 1'b0;
    expect_write("pre_reset_periodl", 8, 3'd2, 16'h1234);
    reset_n = 1'b0; period_load = 1'b1; period_in = 32'h0000_ABCD;
    cyc();
    chk("mid_reset_outputs", 64'({bus_if.tmr_chipselect, bus_if.tmr_write_n, bus_if.tmr_address,
                                  bus_if.tmr_writedata, tick, busy, bcd_count}),
        64'({1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000}));
    reset_n = 1'b1; period_load = 1'b0;
    expect_write("restart_periodl", 4, 3'd2, 16'h783F);
    expect_next_write("restart_periodh", 3'd3, 16'h017D);
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
